vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates raster timing for the VGA text console and any other pixel consumers. It runs free-running horizontal and vertical counters and derives hsync, vsync, visible and pixel coordinates from them, with programmable sync polarity. It sits directly upstream of the text console and drives its vga_hsync, vga_vsync and vga_visible inputs from the same vga_clk.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POSITIVE, 0, 1 = hsync active high, 0 = active low
VSYNC_POSITIVE, 0, 1 = vsync active high, 0 = active low

Ports:
vga_clk  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
pix_en  input  1  pixel advance enable; hold state when 0
vga_hsync  output  1  horizontal sync, polarity per HSYNC_POSITIVE
vga_vsync  output  1  vertical sync, polarity per VSYNC_POSITIVE
vga_visible  output  1  current pixel is in the active area
pixel_x  output  HW  horizontal position, HW = $clog2(H_TOTAL)
pixel_y  output  VW  vertical position, VW = $clog2(V_TOTAL)
line_start  output  1  one-pixel pulse at pixel_x == 0
frame_start  output  1  one-pixel pulse at pixel_x == 0 and pixel_y == 0

Behaviour:
- Definitions: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 525).
- Internal counters h_cnt and v_cnt. When reset=1, both are set to 0.
- Counter advance happens only when pix_en=1:
  - h_cnt increments and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt wraps, and itself wraps from V_TOTAL-1 to 0.
  - When pix_en=0, the counters and all outputs hold.
- All outputs are registered from the pre-increment counter value: on each advancing edge, the outputs take the decode of the current (h_cnt, v_cnt) while the counters move to the next position. Latency from counter to outputs is therefore 1 cycle, and all outputs describe the same pixel in the same cycle.
- Decode for position (h, v):
  - hsync active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC.
  - vsync active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC. vsync changes at h == 0, i.e. whole lines.
  - visible = (h < H_VISIBLE) && (v < V_VISIBLE).
  - pixel_x = h, pixel_y = v. Coordinates are also reported during blanking.
  - line_start = (h == 0). frame_start = (h == 0) && (v == 0).
- Reset values of outputs:
  - vga_hsync = ~HSYNC_POSITIVE and vga_vsync = ~VSYNC_POSITIVE, i.e. both inactive.
  - vga_visible = 0, pixel_x = 0, pixel_y = 0, line_start = 0, frame_start = 0.
- First advancing edge after reset release: outputs show (0,0) with visible=1, line_start=1 and frame_start=1. The counters move to (1,0).
- Reset mid-frame returns to the same state in the same cycle. No partial-frame completion.
- Reset takes priority over pix_en.
- Widths: every compare is done at counter width. The parameters must satisfy H_TOTAL >= 2 and V_TOTAL >= 2, and each sync width >= 1.

Optional Feature:
Macro: VGA_TIMING_GEN_FRAME_COUNT_EN.
- Defined: adds an output frame_count [15:0]. It resets to 0 and increments by 1, with 16-bit wrap, on the same advancing edge where frame_start is registered as 1. It therefore reads 1 during the first frame after reset.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then pix_en=1 constant, default params -> first edge: pixel_x=0, pixel_y=0, visible=1, frame_start=1. pixel_x=799 is followed by pixel_x=0 with pixel_y=1.
- Count one line -> visible high for exactly 640 cycles. vga_hsync low (active-low default) for exactly 96 cycles, starting at pixel_x=656.
- Count one full frame -> frame_start period is exactly 420000 cycles. vga_vsync low for exactly 1600 cycles (2 lines), starting at pixel_y=490, pixel_x=0.
- pix_en toggled 1/0 alternately -> outputs hold on pix_en=0 cycles, and the frame period becomes 840000 clocks.
- Assert reset at pixel_y=300, pixel_x=400 for 1 cycle -> outputs go to reset values. The next advancing edge gives (0,0) with frame_start=1.
- HSYNC_POSITIVE=1, VSYNC_POSITIVE=1, with VGA_TIMING_GEN_FRAME_COUNT_EN defined -> syncs idle low and pulse high at the same positions. frame_count reads 1, 2, 3 across three frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered sync, visible and coordinates.
// Optional frame counter output enabled by defining VGA_TIMING_GEN_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE      = 640,
  parameter int unsigned H_FRONT        = 16,
  parameter int unsigned H_SYNC         = 96,
  parameter int unsigned H_BACK         = 48,
  parameter int unsigned V_VISIBLE      = 480,
  parameter int unsigned V_FRONT        = 10,
  parameter int unsigned V_SYNC         = 2,
  parameter int unsigned V_BACK         = 33,
  parameter bit          HSYNC_POSITIVE = 1'b0,
  parameter bit          VSYNC_POSITIVE = 1'b0,
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_visible,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  // Sync windows use the last active position so no bound ever equals the total.
  localparam logic [HW-1:0] HMax       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HVis       = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HSyncFirst = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HSyncLast  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VMax       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VVis       = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VSyncFirst = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VSyncLast  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, vsync_q, visible_q, line_start_q, frame_start_q;
  logic [HW-1:0] pixel_x_q;
  logic [VW-1:0] pixel_y_q;
  logic          hsync_d, vsync_d, visible_d, line_start_d, frame_start_d;
  logic          h_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == HMax);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VMax) ? '0 : v_cnt_q + 1'b1;
    end
    // Equality with the polarity bit maps "active" onto the configured level.
    hsync_d       = ((h_cnt_q >= HSyncFirst) && (h_cnt_q <= HSyncLast)) == HSYNC_POSITIVE;
    vsync_d       = ((v_cnt_q >= VSyncFirst) && (v_cnt_q <= VSyncLast)) == VSYNC_POSITIVE;
    visible_d     = (h_cnt_q < HVis) && (v_cnt_q < VVis);
    line_start_d  = (h_cnt_q == '0);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HSYNC_POSITIVE;
      vsync_q       <= ~VSYNC_POSITIVE;
      visible_q     <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      pixel_x_q     <= h_cnt_q;
      pixel_y_q     <= v_cnt_q;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (pix_en && frame_start_d) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_visible = visible_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, two polarity variants, position model built from the
// count of advancing edges since reset.
module tb_vga_timing_gen;
  localparam int unsigned HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FR = HT * VT;
  localparam int unsigned HW = $clog2(HT);
  localparam int unsigned VW = $clog2(VT);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;
  logic hs_a, vs_a, vis_a, ls_a, fs_a, hs_b, vs_b, vis_b, ls_b, fs_b;
  logic [HW-1:0] x_a, x_b;
  logic [VW-1:0] y_a, y_b;
`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int n_adv = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POSITIVE(1'b0), .VSYNC_POSITIVE(1'b0)
  ) u_dut_a (
    .vga_clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_visible(vis_a),
    .pixel_x(x_a), .pixel_y(y_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
    , .frame_count(fc_a)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POSITIVE(1'b1), .VSYNC_POSITIVE(1'b1)
  ) u_dut_b (
    .vga_clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_visible(vis_b),
    .pixel_x(x_b), .pixel_y(y_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
    , .frame_count(fc_b)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Outputs after n advancing edges describe linear position n-1 within the frame.
  task automatic check_model();
    int p, h, v, fc;
    bit vis, ls, fs, hact, vact;
    if (n_adv == 0) begin
      h = 0; v = 0; vis = 0; ls = 0; fs = 0; hact = 0; vact = 0; fc = 0;
    end else begin
      p    = (n_adv - 1) % FR;
      h    = p % HT;
      v    = p / HT;
      vis  = (h < HV) && (v < VV);
      ls   = (h == 0);
      fs   = (p == 0);
      hact = (h >= HV + HF) && (h < HV + HF + HS);
      vact = (v >= VV + VF) && (v < VV + VF + VS);
      fc   = ((n_adv - 1) / FR + 1) % 65536;
    end
    check("a_pixel_x", int'(x_a), h);
    check("a_pixel_y", int'(y_a), v);
    check("a_visible", int'(vis_a), int'(vis));
    check("a_line_start", int'(ls_a), int'(ls));
    check("a_frame_start", int'(fs_a), int'(fs));
    check("a_hsync", int'(hs_a), hact ? 0 : 1);
    check("a_vsync", int'(vs_a), vact ? 0 : 1);
    check("b_pixel_x", int'(x_b), h);
    check("b_pixel_y", int'(y_b), v);
    check("b_visible", int'(vis_b), int'(vis));
    check("b_frame_start", int'(fs_b), int'(fs));
    check("b_hsync", int'(hs_b), hact ? 1 : 0);
    check("b_vsync", int'(vs_b), vact ? 1 : 0);
`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
    check("a_frame_count", int'(fc_a), fc);
    check("b_frame_count", int'(fc_b), fc);
`endif
  endtask

  task automatic step(input logic r, input logic e);
    reset  = r;
    pix_en = e;
    @(posedge clk);
    #1;
    cyc++;
    if (r) n_adv = 0;
    else if (e) n_adv++;
    check_model();
  endtask

  typedef struct {
    logic r; logic e;
    int x; int y; logic vis; logic ls; logic fs; logic hs;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int cnt_vis, cnt_hs, first_hs_x, cnt_vs, first_vs_x, first_vs_y, t0, t1;
    logic prev_fs;

    vecs[0] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].r, vecs[i].e);
      check("vec_x", int'(x_a), vecs[i].x);
      check("vec_y", int'(y_a), vecs[i].y);
      check("vec_visible", int'(vis_a), int'(vecs[i].vis));
      check("vec_line_start", int'(ls_a), int'(vecs[i].ls));
      check("vec_frame_start", int'(fs_a), int'(vecs[i].fs));
      check("vec_hsync", int'(hs_a), int'(vecs[i].hs));
    end

    // One line: visible and hsync widths, hsync start position, then wrap to next line.
    step(1'b1, 1'b1);
    cnt_vis = 0; cnt_hs = 0; first_hs_x = -1;
    for (int i = 0; i < HT; i++) begin
      step(1'b0, 1'b1);
      if (vis_a) cnt_vis++;
      if (!hs_a) begin
        if (first_hs_x < 0) first_hs_x = int'(x_a);
        cnt_hs++;
      end
    end
    check("line_visible_width", cnt_vis, HV);
    check("line_hsync_width", cnt_hs, HS);
    check("line_hsync_start_x", first_hs_x, HV + HF);
    step(1'b0, 1'b1);
    check("wrap_x", int'(x_a), 0);
    check("wrap_y", int'(y_a), 1);

    // Full frames: vsync width and start, frame_start period.
    step(1'b1, 1'b1);
    cnt_vs = 0; first_vs_x = -1; first_vs_y = -1; t0 = -1; t1 = -1;
    for (int i = 0; i < 2 * FR + 1; i++) begin
      step(1'b0, 1'b1);
      if (fs_a) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
      if (i < FR && !vs_a) begin
        if (first_vs_y < 0) begin
          first_vs_x = int'(x_a);
          first_vs_y = int'(y_a);
        end
        cnt_vs++;
      end
    end
    check("frame_vsync_width", cnt_vs, VS * HT);
    check("frame_vsync_start_x", first_vs_x, 0);
    check("frame_vsync_start_y", first_vs_y, VV + VF);
    check("frame_period", (t0 < 0 || t1 < 0) ? -1 : t1 - t0, FR);

    // Alternating pix_en doubles the frame period in clocks.
    step(1'b1, 1'b1);
    t0 = -1; t1 = -1; prev_fs = 1'b0;
    for (int i = 0; i < 4 * FR + 2; i++) begin
      step(1'b0, (i % 2) == 0);
      if (fs_a && !prev_fs) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
      prev_fs = fs_a;
    end
    check("alt_frame_period", (t0 < 0 || t1 < 0) ? -1 : t1 - t0, 2 * FR);

    // Reset mid-frame at (5,3).
    step(1'b1, 1'b1);
    for (int i = 0; i < 3 * HT + 5 + 1; i++) step(1'b0, 1'b1);
    check("mid_x", int'(x_a), 5);
    check("mid_y", int'(y_a), 3);
    step(1'b1, 1'b1);
    check("mid_reset_x", int'(x_a), 0);
    check("mid_reset_visible", int'(vis_a), 0);
    check("mid_reset_frame_start", int'(fs_a), 0);
    step(1'b0, 1'b1);
    check("after_reset_y", int'(y_a), 0);
    check("after_reset_frame_start", int'(fs_a), 1);

`ifdef VGA_TIMING_GEN_FRAME_COUNT_EN
    step(1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1);
      check("frame_count_seq", int'(fc_b), k);
      for (int i = 1; i < FR; i++) step(1'b0, 1'b1);
    end
`endif

    // Randomised enable with occasional reset, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
